// File: rtl/vend_pkg.sv
// Shared types and defaults for the vend dispense sequencer.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MOTOR,
    ST_WAIT_DROP,
    ST_DONE,
    ST_FAIL
  } vend_state_e;

  localparam int DEF_MOTOR_CYCLES = 16;
  localparam int DEF_DROP_TIMEOUT = 64;
  localparam int DEF_MAX_RETRY    = 2;
  localparam int MAX_SLOTS        = 32;

  function automatic logic [MAX_SLOTS-1:0] onehot_dec(input logic [4:0] idx);
    return {{(MAX_SLOTS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/vend_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module vend_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/vend_dispense_sequencer.sv
// Dispense sequencer: pulses one slot motor, watches the drop sensor,
// retries on a missed drop and reports done or fail+refund.
//
// state     | meaning
// IDLE      | waiting for a request (ready unless cfg_mode)
// MOTOR     | driving the latched slot motor
// WAIT_DROP | motor off, waiting for the drop sensor
// DONE      | one-cycle vend_done pulse
// FAIL      | one-cycle vend_fail + refund_req pulse
module vend_dispense_sequencer
  import vend_pkg::*;
#(
  parameter int NUM_SLOTS    = 8,
  parameter int SLOT_W       = 3,
  parameter int MOTOR_CYCLES = DEF_MOTOR_CYCLES,
  parameter int DROP_TIMEOUT = DEF_DROP_TIMEOUT,
  parameter int MAX_RETRY    = DEF_MAX_RETRY,
  parameter int CNT_W        = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 cfg_mode,
  input  logic                 req_valid,
  input  logic [SLOT_W-1:0]    req_slot,
  output logic                 req_ready,
  output logic [NUM_SLOTS-1:0] motor_en,
  input  logic                 drop_sensor,
  output logic                 vend_done,
  output logic                 vend_fail,
  output logic                 refund_req,
  output logic                 busy
);

  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CNT_W-1:0] MOTOR_LOAD = CNT_W'(MOTOR_CYCLES - 1);
  localparam logic [CNT_W-1:0] DROP_LOAD  = CNT_W'(DROP_TIMEOUT - 1);

  vend_state_e        state_q, state_d;
  logic [SLOT_W-1:0]  slot_q;
  logic [RETRY_W-1:0] retry_q;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_en;
  logic             tmr_expired;
  logic             slot_ld;
  logic             retry_clr;
  logic             retry_inc;
  logic             handshake;
  logic             slot_ok;

  vend_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .expired  (tmr_expired)
  );

  assign handshake = req_valid && req_ready;
  assign slot_ok   = ({1'b0, req_slot} < (SLOT_W+1)'(NUM_SLOTS));
  assign tmr_en    = (state_q == ST_MOTOR) || (state_q == ST_WAIT_DROP);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      if (slot_ld) slot_q <= req_slot;
      if (retry_clr) begin
        retry_q <= '0;
      end else if (retry_inc) begin
        retry_q <= retry_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    tmr_load  = 1'b0;
    tmr_val   = MOTOR_LOAD;
    slot_ld   = 1'b0;
    retry_clr = 1'b0;
    retry_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          slot_ld   = 1'b1;
          retry_clr = 1'b1;
          tmr_load  = 1'b1;
          state_d   = slot_ok ? ST_MOTOR : ST_FAIL;
        end
      end
      ST_MOTOR: begin
        if (cfg_mode) begin
          state_d = ST_FAIL;
        end else if (drop_sensor) begin
          state_d = ST_DONE;
        end else if (tmr_expired) begin
          state_d  = ST_WAIT_DROP;
          tmr_load = 1'b1;
          tmr_val  = DROP_LOAD;
        end
      end
      ST_WAIT_DROP: begin
        // abort beats drop, and drop beats a coincident timeout
        if (cfg_mode) begin
          state_d = ST_FAIL;
        end else if (drop_sensor) begin
          state_d = ST_DONE;
        end else if (tmr_expired) begin
          if (retry_q < RETRY_W'(MAX_RETRY)) begin
            retry_inc = 1'b1;
            tmr_load  = 1'b1;
            state_d   = ST_MOTOR;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_FAIL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  logic [NUM_SLOTS-1:0] motor_dec;
  assign motor_dec = NUM_SLOTS'(onehot_dec(5'(slot_q)));

  assign req_ready  = (state_q == ST_IDLE) && !cfg_mode;
  assign motor_en   = (state_q == ST_MOTOR) ? motor_dec : '0;
  assign vend_done  = (state_q == ST_DONE);
  assign vend_fail  = (state_q == ST_FAIL);
  assign refund_req = (state_q == ST_FAIL);
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vend_dispense_sequencer.sv
// Directed self-checking bench for vend_dispense_sequencer (4-bit slot index
// so that an out-of-range slot can be requested).
module tb_vend_dispense_sequencer;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       cfg_mode = 1'b0;
  logic       req_valid = 1'b0;
  logic [3:0] req_slot = '0;
  logic       req_ready;
  logic [7:0] motor_en;
  logic       drop_sensor = 1'b0;
  logic       vend_done;
  logic       vend_fail;
  logic       refund_req;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  vend_dispense_sequencer #(
    .NUM_SLOTS(8), .SLOT_W(4), .MOTOR_CYCLES(16), .DROP_TIMEOUT(64),
    .MAX_RETRY(2), .CNT_W(8)
  ) dut (
    .clk(clk), .rstn(rstn), .cfg_mode(cfg_mode), .req_valid(req_valid),
    .req_slot(req_slot), .req_ready(req_ready), .motor_en(motor_en),
    .drop_sensor(drop_sensor), .vend_done(vend_done), .vend_fail(vend_fail),
    .refund_req(refund_req), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller is at cycle 0; returns at cycle 1 with req_valid dropped.
  task automatic accept(input logic [3:0] slot);
    chk("accept_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_slot  = slot;
    step();
    req_valid = 1'b0;
  endtask

  int motor_cnt, done_cnt, fail_cnt, bursts, done_cyc, fail_cyc, bad_drive;
  logic prev_on;

  initial begin
    // reset state
    #12;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_motor", 32'(motor_en), 32'd0);
    chk("rst_outs", {busy, vend_done, vend_fail, refund_req}, 32'd0);
    rstn = 1'b1;
    step();
    step();

    // normal vend: slot 3, drop at cycle 10
    accept(4'd3);
    bad_drive = 0;
    for (int c = 1; c <= 10; c++) begin
      if (motor_en !== 8'h08) bad_drive++;
      drop_sensor = (c == 10);
      step();
    end
    drop_sensor = 1'b0;
    chk("norm_motor_1_10", 32'(bad_drive), 32'd0);
    chk("norm_done_c11", {motor_en, vend_done, vend_fail, req_ready}, {8'h00, 3'b100});
    step();
    chk("norm_ready_c12", {req_ready, busy}, 32'b10);

    // late drop: slot 5, drop at cycle 36 (WAIT_DROP cycle 20)
    accept(4'd5);
    motor_cnt = 0; done_cnt = 0; fail_cnt = 0; done_cyc = 0; bad_drive = 0;
    for (int c = 1; c <= 60; c++) begin
      if (motor_en != 0) motor_cnt++;
      if (motor_en != 0 && motor_en !== 8'h20) bad_drive++;
      if (vend_done) begin done_cnt++; done_cyc = c; end
      if (vend_fail) fail_cnt++;
      drop_sensor = (c == 36);
      step();
    end
    drop_sensor = 1'b0;
    chk("late_motor_cycles", 32'(motor_cnt), 32'd16);
    chk("late_motor_value", 32'(bad_drive), 32'd0);
    chk("late_done_cnt", 32'(done_cnt), 32'd1);
    chk("late_done_cyc", 32'(done_cyc), 32'd37);
    chk("late_no_fail", 32'(fail_cnt), 32'd0);

    // full failure: slot 0, never drops
    accept(4'd0);
    motor_cnt = 0; done_cnt = 0; fail_cnt = 0; fail_cyc = 0; bursts = 0;
    bad_drive = 0; prev_on = 1'b0;
    for (int c = 1; c <= 260; c++) begin
      if (motor_en != 0) motor_cnt++;
      if (motor_en != 0 && motor_en !== 8'h01) bad_drive++;
      if (motor_en != 0 && !prev_on) bursts++;
      prev_on = (motor_en != 0);
      if (vend_done) done_cnt++;
      if (vend_fail) begin
        fail_cnt++; fail_cyc = c;
        if (!refund_req) bad_drive++;
      end
      step();
    end
    chk("ff_motor_cycles", 32'(motor_cnt), 32'd48);
    chk("ff_bursts", 32'(bursts), 32'd3);
    chk("ff_drive_refund", 32'(bad_drive), 32'd0);
    chk("ff_fail_cnt", 32'(fail_cnt), 32'd1);
    chk("ff_fail_cyc", 32'(fail_cyc), 32'd241);
    chk("ff_no_done", 32'(done_cnt), 32'd0);

    // abort: slot 2, cfg_mode at MOTOR cycle 5
    accept(4'd2);
    for (int c = 1; c <= 4; c++) step();
    chk("abort_motor_c5", 32'(motor_en), 32'h04);
    cfg_mode = 1'b1;
    step();
    chk("abort_c6", {motor_en, vend_fail, refund_req, req_ready}, {8'h00, 3'b110});
    req_valid = 1'b1;
    req_slot  = 4'd1;
    step();
    chk("abort_cfg_ready", {req_ready, busy}, 32'b00);
    step();
    chk("abort_cfg_ignored", {busy, motor_en}, 32'd0);
    req_valid = 1'b0;
    cfg_mode  = 1'b0;
    #1;
    chk("abort_ready_back", 32'(req_ready), 32'd1);
    step();

    // bad slot 8
    accept(4'd8);
    chk("bad_slot_c1", {motor_en, vend_fail, refund_req}, {8'h00, 2'b11});
    step();
    chk("bad_slot_c2", {busy, req_ready}, 32'b01);

    // drop on final WAIT_DROP cycle with retries exhausted
    accept(4'd1);
    done_cnt = 0; fail_cnt = 0; done_cyc = 0;
    for (int c = 1; c <= 250; c++) begin
      if (vend_done) begin done_cnt++; done_cyc = c; end
      if (vend_fail) fail_cnt++;
      drop_sensor = (c == 240);
      step();
    end
    drop_sensor = 1'b0;
    chk("sim_done_cyc", 32'(done_cyc), 32'd241);
    chk("sim_counts", {16'(done_cnt), 16'(fail_cnt)}, {16'd1, 16'd0});

    // reset mid-MOTOR
    accept(4'd3);
    step();
    step();
    chk("rm_motor_pre", 32'(motor_en), 32'h08);
    rstn = 1'b0;
    #1;
    chk("rm_async", {motor_en, req_ready, vend_done, vend_fail, refund_req, busy},
        {8'h00, 5'b10000});
    step();
    chk("rm_held", {motor_en, vend_done, vend_fail}, 32'd0);
    rstn = 1'b1;
    step();
    chk("rm_idle_after", {req_ready, busy}, 32'b10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
